// File: rtl/disp_scan_driver_pkg.sv
// Shared constants for the 8-digit scanned 7-segment display driver.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package disp_scan_driver_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] HEX7SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/disp_scan_driver_if.sv
// Debug-word inputs and display pins of the scan driver.
// The master side supplies the word; the slave side drives the display.
interface disp_scan_driver_if;

    logic [31:0] disdata;
    logic        freeze;
    logic [7:0]  dp_mask;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output disdata, freeze, dp_mask,
        input  an, seg, dp
    );

    modport slave (
        input  disdata, freeze, dp_mask,
        output an, seg, dp
    );

endinterface

// File: rtl/disp_scan_driver_hex7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module disp_scan_driver_hex7seg
    import disp_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX7SEG_LUT[nibble];
    end

endmodule

// File: rtl/disp_scan_driver.sv
// Time-multiplexed 8-digit common-anode display driver with frame-consistent
// snapshot, freeze and optional leading-zero blanking.
module disp_scan_driver
    import disp_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int DIV_W       = 17,
    parameter int BLANK_LZ    = 0
)
(
    input  logic                clk,
    input  logic                reset,
    disp_scan_driver_if.slave   bus
);

    localparam logic [DIV_W-1:0] CNT_MAX = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      snap_q, snap_d;
    logic             load_pend_q, load_pend_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             tick;
    logic             load;
    logic             blank;
    logic [3:0]       nibble;
    logic [6:0]       seg_dec;

    assign nibble = snap_q[{idx_q, 2'b00} +: 4];

    disp_scan_driver_hex7seg u_hex7seg (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    always_comb begin
        tick        = (cnt_q == CNT_MAX);
        cnt_d       = tick ? '0 : cnt_q + DIV_W'(1);
        idx_d       = tick ? idx_q + IDX_W'(1) : idx_q;

        // Reloading only at the 7->0 wrap keeps every frame drawn from one word.
        load        = !bus.freeze && (load_pend_q || (tick && idx_q == IDX_MAX));
        snap_d      = load ? bus.disdata : snap_q;
        load_pend_d = load ? 1'b0 : load_pend_q;

        blank       = (BLANK_LZ != 0) && (idx_q != '0) &&
                      ((snap_q >> {idx_q, 2'b00}) == 32'd0);

        an_d        = ~(8'b1 << idx_q);
        seg_d       = blank ? SEG_BLANK : seg_dec;
        dp_d        = ~bus.dp_mask[idx_q];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            snap_q      <= '0;
            load_pend_q <= 1'b1;
            an_q        <= 8'hFF;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            load_pend_q <= load_pend_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule
